// File: rtl/array_frame_packer.sv
// array_frame_packer
// Collects a serial stream of WIDTH-bit elements (valid/ready) into a
// ROWS x COLS frame, filled row-major, and presents the complete frame as a
// single packed word with its own valid/ready handshake.  A frame release and
// the first element of the next frame may share a cycle, so a continuous
// stream runs without bubbles.
module array_frame_packer #(
   parameter int WIDTH = 4,
   parameter int ROWS  = 3,
   parameter int COLS  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        clear,
   output logic [ROWS*COLS*WIDTH-1:0]  out_data,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int N     = ROWS * COLS;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]       state;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [WIDTH-1:0] elem [N];

   logic             accept;
   logic             release_frame;
   logic             last_elem;
   logic [IDX_W-1:0] wr_idx;

   // Handshake decode and write address of the next element (row-major).
   always_comb begin
      in_ready      = !rst && ((state == ST_FILL) || out_ready);
      accept        = in_valid && in_ready;
      release_frame = (state == ST_HOLD) && out_ready;
      last_elem     = (row == ROW_LAST) && (col == COL_LAST);
      wr_idx        = IDX_W'(int'(row) * COLS + int'(col));
   end

   // FSM, fill counters and element storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FILL;
         row   <= '0;
         col   <= '0;
         // NOTE: the element array is reset on purpose: out_data must read
         // as zero after reset, so this is not a plain storage RAM.
         for (int i = 0; i < N; i++) elem[i] <= '0;
      end else if (clear && (state == ST_FILL)) begin
         // Abort the partial frame; the element offered this cycle is dropped.
         row <= '0;
         col <= '0;
      end else begin
         // NOTE: a later non-blocking assignment to state in this block wins,
         // so a release and a simultaneous frame completion resolve to HOLD.
         if (release_frame) state <= ST_FILL;
         if (accept) begin
            elem[wr_idx] <= in_data;
            if (last_elem) begin
               row   <= '0;
               col   <= '0;
               state <= ST_HOLD;
            end else if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Flatten the element array onto the output word; element (r,c) sits at
   // index r*COLS+c.  Only registered contents reach out_data.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < N; i++) out_data[i*WIDTH +: WIDTH] = elem[i];
      out_valid = (state == ST_HOLD);
   end

endmodule

// File: tb/tb_array_frame_packer.sv
// Testbench for array_frame_packer: directed scenarios plus a randomized run,
// all compared against a queue-based frame model kept in the bench.
module tb_array_frame_packer;

   localparam int WIDTH = 4;
   localparam int ROWS  = 3;
   localparam int COLS  = 2;
   localparam int N     = ROWS * COLS;
   localparam int FW    = N * WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             clear;
   logic [FW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: elements collected so far, and the held frame.
   logic [WIDTH-1:0] m_cur [$];
   bit               m_hold;
   logic [FW-1:0]    m_frame;

   always #5 clk = ~clk;

   array_frame_packer #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clear     (clear),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Arrival order is row-major order, so the i-th element lands at slot i.
   function automatic logic [FW-1:0] pack(input logic [WIDTH-1:0] q [$]);
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < q.size(); i++) f[i*WIDTH +: WIDTH] = q[i];
      return f;
   endfunction

   // Advance the model with the inputs currently driven, then one clock.
   task automatic step();
      bit rel;
      bit acc;
      if (rst) begin
         m_cur.delete();
         m_hold  = 1'b0;
         m_frame = '0;
      end else begin
         rel = m_hold && out_ready;
         acc = in_valid && (!m_hold || out_ready);
         if (clear && !m_hold) begin
            m_cur.delete();
         end else begin
            if (rel) m_hold = 1'b0;
            if (acc) begin
               m_cur.push_back(in_data);
               if (m_cur.size() == N) begin
                  m_frame = pack(m_cur);
                  m_cur.delete();
                  m_hold = 1'b1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 4'h7;
      step();
      step();
      n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data); else n_pass++;
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready); else n_pass++;
   endtask

   task automatic test_basic_fill();
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= N; i++) begin
         n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0 before elem %0d", out_valid, i); else n_pass++;
         send(WIDTH'(i));
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else n_pass++;
      n_checks++; if (out_data !== 24'h654321) $display("FAIL basic_data: got %h expected 654321", out_data); else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle: got %b expected 0", out_valid); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] q [$];
      logic [FW-1:0]    saved;
      do_reset();
      for (int i = 0; i < N; i++) begin
         q.push_back(WIDTH'($urandom_range(14)));
         send(q[i]);
      end
      in_valid = 1'b1; in_data = 4'hF;
      #1;
      saved = out_data;
      n_checks++; if (saved !== pack(q)) $display("FAIL bp_frame: got %h expected %h", saved, pack(q)); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0 at stall %0d", in_ready, i); else n_pass++;
         n_checks++; if (out_valid !== 1'b1 || out_data !== saved) $display("FAIL bp_hold: got %b/%h expected 1/%h at stall %0d", out_valid, out_data, saved, i); else n_pass++;
         step();
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready); else n_pass++;
      n_checks++; if (out_data !== saved) $display("FAIL bp_release_data: got %h expected %h", out_data, saved); else n_pass++;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_after_release: got %b expected 0", out_valid); else n_pass++;
      for (int i = 0; i < N - 1; i++) send(WIDTH'($urandom_range(14)));
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data[WIDTH-1:0] !== 4'hF) $display("FAIL bp_next_first: got %b/%h expected 1/f", out_valid, out_data[WIDTH-1:0]); else n_pass++;
      n_checks++; if (out_data !== m_frame) $display("FAIL bp_next_frame: got %h expected %h", out_data, m_frame); else n_pass++;
      step();
   endtask

   task automatic test_overlap();
      int            cycs [2];
      logic [FW-1:0] frames [2];
      int            nv;
      do_reset();
      out_ready = 1'b1;
      nv = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         in_valid = (cyc < 12);
         in_data  = WIDTH'(cyc);
         #1;
         if (cyc < 12) begin
            n_checks++; if (in_ready !== 1'b1) $display("FAIL overlap_ready: got %b expected 1 at cycle %0d", in_ready, cyc); else n_pass++;
         end
         step();
         if (out_valid === 1'b1) begin
            if (nv < 2) begin
               cycs[nv]   = cyc;
               frames[nv] = out_data;
            end
            nv++;
         end
      end
      in_valid = 1'b0;
      n_checks++; if (nv !== 2) $display("FAIL overlap_count: got %0d expected 2", nv); else n_pass++;
      if (nv >= 2) begin
         n_checks++; if (frames[0] !== 24'h543210) $display("FAIL overlap_frame0: got %h expected 543210", frames[0]); else n_pass++;
         n_checks++; if (frames[1] !== 24'hBA9876) $display("FAIL overlap_frame1: got %h expected ba9876", frames[1]); else n_pass++;
         n_checks++; if (cycs[1] - cycs[0] !== N) $display("FAIL overlap_spacing: got %0d expected %0d", cycs[1] - cycs[0], N); else n_pass++;
      end
   endtask

   task automatic test_clear_fill();
      do_reset();
      out_ready = 1'b1;
      send(4'hA); send(4'hB); send(4'hC);
      clear = 1'b1;
      send(4'hD);
      clear = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL clear_fill_valid: got %b expected 0", out_valid); else n_pass++;
      for (int i = 1; i <= N; i++) send(WIDTH'(i));
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 24'h654321) $display("FAIL clear_fill_frame: got %b/%h expected 1/654321", out_valid, out_data); else n_pass++;
      step();
   endtask

   task automatic test_clear_hold();
      logic [FW-1:0] saved;
      do_reset();
      for (int i = 0; i < N; i++) send(WIDTH'($urandom));
      in_valid = 1'b0;
      saved = out_data;
      n_checks++; if (saved !== m_frame) $display("FAIL clear_hold_frame: got %h expected %h", saved, m_frame); else n_pass++;
      clear = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (out_valid !== 1'b1 || out_data !== saved) $display("FAIL clear_hold_kept: got %b/%h expected 1/%h", out_valid, out_data, saved); else n_pass++;
      end
      clear = 1'b0; out_ready = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL clear_hold_release: got %b expected 0", out_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] q [$];
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(WIDTH'($urandom));
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_data !== '0) $display("FAIL reset_mid_state: got %b/%h expected 0/0", out_valid, out_data); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b expected 1", in_ready); else n_pass++;
      for (int i = 0; i < N; i++) begin
         q.push_back(WIDTH'($urandom));
         send(q[i]);
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== pack(q)) $display("FAIL reset_mid_frame: got %b/%h expected 1/%h", out_valid, out_data, pack(q)); else n_pass++;
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(99) == 0);
         clear     = ($urandom_range(19) == 0);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_data   = WIDTH'($urandom);
         #1;
         n_checks++; if (in_ready !== (!rst && (!m_hold || out_ready))) $display("FAIL rand_in_ready: got %b expected %b at %0d", in_ready, (!rst && (!m_hold || out_ready)), i); else n_pass++;
         n_checks++; if (out_valid !== m_hold) $display("FAIL rand_out_valid: got %b expected %b at %0d", out_valid, m_hold, i); else n_pass++;
         if (m_hold) begin
            n_checks++; if (out_data !== m_frame) $display("FAIL rand_out_data: got %h expected %h at %0d", out_data, m_frame, i); else n_pass++;
         end
         step();
      end
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      m_hold = 1'b0; m_frame = '0;
      test_reset();
      test_basic_fill();
      test_backpressure();
      test_overlap();
      test_clear_fill();
      test_clear_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/array_frame_packer.md
# array_frame_packer

Upstream feeder for the flattened 2-D array wrapper. It accepts a serial stream of WIDTH-bit elements over a valid/ready handshake and packs them row-major into a ROWS×COLS register frame. It presents the complete frame as one packed word with its own valid/ready handshake. Downstream logic slices that word onto the per-element ports a_r_c of the wrapper.

## Interface
Parameters:
- WIDTH, 4, element width in bits
- ROWS, 3, outer array dimension
- COLS, 2, inner array dimension

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  serial element
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- clear  input  1  synchronous abort of the partially filled frame
- out_data  output  ROWS*COLS*WIDTH  packed frame; element (r,c) occupies bits [(r*COLS+c)*WIDTH +: WIDTH]
- out_valid  output  1  frame complete and held
- out_ready  input  1  consumer takes the frame

## Operation
- State machine with two states:
  - FILL: collecting elements.
  - HOLD: frame complete; out_valid=1.
- Counters:
  - row: $clog2(ROWS) bits, minimum 1.
  - col: $clog2(COLS) bits, minimum 1.
  - Together they address the next element to write.
- Fill order is row-major: (0,0), (0,1), (1,0), … (ROWS-1, COLS-1).
- Accept occurs when in_valid && in_ready. On accept:
  - Write in_data to element (row,col).
  - Advance col. When col wraps from COLS-1 to 0, advance row.
- When the accepted element is (ROWS-1, COLS-1), go FILL→HOLD. Counters wrap to (0,0).
- in_ready is combinational: (state==FILL) || (state==HOLD && out_ready). It is 0 while rst=1.
- Frame release: out_valid && out_ready moves HOLD→FILL.
  - If an input accept happens in the same cycle, that element is written to (0,0) of the next frame. This gives no bubble.
  - The outgoing out_data value is the pre-edge register content, so it is unaffected.
- clear:
  - In FILL: counters reset to (0,0); the element accepted that same cycle is discarded.
  - In HOLD: ignored. A completed frame is never dropped.
- Element registers are not zeroed between frames. Stale contents are don't-care while out_valid=0.
- Once out_valid=1, out_data must remain stable until the handshake completes.
- in_data is never combinationally routed to out_data.

## Timing
- Reset values:
  - state=FILL, row=col=0, out_valid=0, out_data=0.
  - in_ready=0 during reset; in_ready=1 in the first cycle after rst deasserts.
- Latency: last element accepted at edge N gives out_valid=1 in the cycle following edge N. There is no combinational in→out path.
- Throughput: with out_ready held at 1 and in_valid held at 1, one frame every ROWS*COLS cycles. out_valid is asserted for exactly 1 cycle per frame.
- Backpressure: in HOLD with out_ready=0, in_ready=0. Input stalls indefinitely with no loss.
- Reset mid-frame or mid-HOLD: all progress is discarded; the block returns to the reset values on the next edge.
- clear and rst asserted together: rst takes precedence; the result is the same as rst alone.

## Test plan
- Basic fill:
  - Stimulus: after reset, send 0x1,0x2,0x3,0x4,0x5,0x6 back-to-back; out_ready=1.
  - Response: out_valid=1 for one cycle with elements (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4, (2,0)=5, (2,1)=6, i.e. out_data=24'h654321. out_valid rises the cycle after the 6th accept.
- Backpressure:
  - Stimulus: complete a frame with out_ready=0 for 5 cycles while in_valid=1 and in_data=0xF.
  - Response: in_ready=0 and out_data stable for all 5 cycles. Release delivers the original frame; 0xF then lands at (0,0) of the next frame.
- Overlap:
  - Stimulus: out_ready=1 and continuous input 0x0..0xB.
  - Response: two frames, 24'h543210 then 24'hBA9876. out_valid pulses exactly 6 cycles apart with no idle cycle on in_ready.
- Clear mid-frame:
  - Stimulus: send 0xA,0xB,0xC; pulse clear with in_valid=1, in_data=0xD; then send 0x1..0x6.
  - Response: 0xD is discarded. The frame is 24'h654321, with no trace of A/B/C at their positions.
- Clear in HOLD:
  - Stimulus: complete a frame, then assert clear with out_ready=0.
  - Response: out_valid stays 1 and out_data is unchanged.
- Reset mid-frame:
  - Stimulus: accept 4 elements, assert rst for 1 cycle, then send 6 new elements.
  - Response: out_valid=0 and out_data=0 after reset. The next frame contains only the 6 new elements.
